// File: rtl/serial_add_seq.sv
// ============================================================================
// serial_add_seq
// ----------------------------------------------------------------------------
// Bit-serial adder sequencer. One 1-bit full adder is reused over WIDTH clock
// cycles to form a + b + cin, least significant bit first. This trades
// throughput for area compared with a parallel ripple adder.
//
// The block sits between an operand producer and a result consumer, with a
// valid/ready handshake on each side:
//
//   IDLE --(in_valid)--> RUN --(WIDTH bits done)--> DONE --(out_ready)--> IDLE
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-high reset
//   in_valid   in   1      operands a, b, cin are valid this cycle
//   in_ready   out  1      operands can be accepted (high only in IDLE)
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry into bit 0
//   out_valid  out  1      sum/cout valid; held until consumed
//   out_ready  in   1      consumer takes the result this cycle
//   sum        out  WIDTH  low WIDTH bits of a + b + cin
//   cout       out  1      carry out of bit WIDTH-1
//   busy       out  1      high while bits are being computed (RUN)
//
// Parameters
//   WIDTH      operand/result width in bits, legal range 1..64
// ============================================================================

// ----------------------------------------------------------------------------
// full_adder
// ----------------------------------------------------------------------------
// Plain 1-bit full adder; the only arithmetic element of the sequencer.
//
// Ports
//   a, b   in   1   addend bits
//   ci     in   1   carry in
//   s      out  1   sum bit
//   co     out  1   carry out
// ----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic half_sum;

    assign half_sum = a ^ b;
    assign s        = half_sum ^ ci;
    assign co       = (a & b) | (ci & half_sum);

endmodule

// ----------------------------------------------------------------------------
// serial_add_seq (top)
// ----------------------------------------------------------------------------
module serial_add_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    // Counter is one bit wider than strictly needed so WIDTH=1 still gets a
    // legal 1-bit counter and powers of two never alias to zero.
    localparam int CNT_W = $clog2(WIDTH) + 1;

    // Bit index of the final RUN cycle.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   op_a_q,   op_a_d;   // operand A, shifts right each bit
    logic [WIDTH-1:0]   op_b_q,   op_b_d;   // operand B, shifts right each bit
    logic [WIDTH-1:0]   acc_q,    acc_d;    // result, fills from the MSB end
    logic               carry_q,  carry_d;  // running carry between bits
    logic [CNT_W-1:0]   cnt_q,    cnt_d;    // index of the bit being added

    // ------------------------------------------------------------------------
    // Datapath: the single shared full adder
    // ------------------------------------------------------------------------
    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] acc_shift;

    full_adder u_fa (
        .a  (op_a_q[0]),
        .b  (op_b_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // Each new sum bit enters at the MSB and everything older moves down one
    // place; after WIDTH bits the LSB-first stream lands in natural order.
    // A 1-bit accumulator has nothing to shift, so it just takes the bit.
    generate
        if (WIDTH == 1) begin : g_acc_w1
            assign acc_shift = fa_s;
        end else begin : g_acc_wn
            assign acc_shift = {fa_s, acc_q[WIDTH-1:1]};
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Register bank
    // ------------------------------------------------------------------------
    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples the pre-edge value of every other flop.
    // NOTE: every register, including the datapath shift registers, is reset;
    // that makes sum/cout read 0 straight after reset and guarantees no stale
    // carry from an aborted operation leaks into the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------------
    // NOTE: every signal written here is given a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                // in_ready is high in IDLE, so in_valid alone completes the
                // handshake. Operands are captured here and never re-read.
                if (in_valid) begin
                    op_a_d  = a;
                    op_b_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                acc_d   = acc_shift;
                carry_d = fa_co;
                op_a_d  = op_a_q >> 1;
                op_b_d  = op_b_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                // acc/carry are left untouched so sum/cout stay stable for as
                // long as the consumer stalls.
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs: decoded straight from state, results straight from registers
    // ------------------------------------------------------------------------
    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_RUN);
    assign out_valid = (state_q == ST_DONE);
    assign sum       = acc_q;
    assign cout      = carry_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// ============================================================================
// tb_serial_add_seq
// ----------------------------------------------------------------------------
// Self-checking bench for serial_add_seq. A 32-bit instance covers directed
// cases, reset mid-operation, operand changes during RUN and 1000 random
// additions under random consumer back-pressure. A 1-bit instance covers the
// degenerate width over all eight input combinations. Expected results come
// from plain integer addition of the operands.
// ============================================================================
module tb_serial_add_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;

    // 32-bit instance
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    // 1-bit instance
    logic         in_valid1 = 1'b0;
    logic         in_ready1;
    logic [0:0]   a1 = '0;
    logic [0:0]   b1 = '0;
    logic         cin1 = 1'b0;
    logic         out_valid1;
    logic         out_ready1 = 1'b0;
    logic [0:0]   sum1;
    logic         cout1;
    logic         busy1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_add_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    serial_add_seq #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .cout      (cout1),
        .busy      (busy1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge: inputs are driven and
    // outputs sampled here, well away from the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction on the 32-bit instance.
    //   hold_low : cycles out_ready stays low once out_valid is seen
    //   scramble : randomise a/b/cin/in_valid/out_ready while busy
    task automatic do_add(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tcin, input int hold_low, input bit scramble);
        logic [W:0] exp;
        int         run_cycles;
        int         budget;

        exp = {1'b0, ta} + {1'b0, tb_v} + {{W{1'b0}}, tcin};

        check("in_ready_idle", in_ready, 1);
        a        = ta;
        b        = tb_v;
        cin      = tcin;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;

        run_cycles = 0;
        budget     = 0;
        while (!out_valid && budget < 4 * W) begin
            if (busy) run_cycles++;
            budget++;
            if (scramble) begin
                a         = $urandom;
                b         = $urandom;
                cin       = 1'($urandom);
                in_valid  = 1'($urandom);
                out_ready = 1'($urandom);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        check("out_valid_rise", out_valid, 1);
        check("busy_cycles", run_cycles, W);
        check("busy_low_done", busy, 0);

        for (int i = 0; i < hold_low; i++) begin
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_sum", sum, exp[W-1:0]);
            check("hold_cout", cout, exp[W]);
            tick();
        end

        out_ready = 1'b1;
        check("sum", sum, exp[W-1:0]);
        check("cout", cout, exp[W]);
        tick();
        out_ready = 1'b0;
        check("valid_drop", out_valid, 0);
        check("in_ready_back", in_ready, 1);
    endtask

    // One complete transaction on the 1-bit instance.
    task automatic do_add1(input logic ta, input logic tb_v, input logic tcin);
        logic [1:0] exp;
        exp = {1'b0, ta} + {1'b0, tb_v} + {1'b0, tcin};

        check("w1_in_ready", in_ready1, 1);
        a1        = ta;
        b1        = tb_v;
        cin1      = tcin;
        in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        check("w1_busy", busy1, 1);
        check("w1_not_valid_yet", out_valid1, 0);
        tick();
        check("w1_out_valid", out_valid1, 1);
        check("w1_sum", sum1, exp[0]);
        check("w1_cout", cout1, exp[1]);
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        check("w1_valid_drop", out_valid1, 0);
    endtask

    initial begin
        // ---------------- reset state ----------------
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        tick();
        reset = 1'b0;
        tick();

        // ---------------- directed cases ----------------
        do_add(32'h0000_0003, 32'h0000_0004, 1'b0, 0, 1'b0);
        do_add(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0, 1'b0);
        do_add(32'h8000_0000, 32'h8000_0000, 1'b0, 10, 1'b0);
        do_add(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1, 1'b0);

        // ---------------- reset mid-RUN ----------------
        a        = 32'h1234_5678;
        b        = 32'h0F0F_0F0F;
        cin      = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        check("pre_rst_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_sum", sum, 0);
        check("midrst_cout", cout, 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_stale_pulse", out_valid, 0);
        end
        do_add(32'd5, 32'd6, 1'b0, 0, 1'b0);

        // ---------------- inputs changing during RUN ----------------
        do_add(32'hDEAD_BEEF, 32'h1357_9BDF, 1'b1, 2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("single_result", out_valid, 0);
        end

        // ---------------- WIDTH = 1 ----------------
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            do_add1(v[2], v[1], v[0]);
        end

        // ---------------- random vectors with back-pressure ----------------
        for (int i = 0; i < 1000; i++) begin
            do_add($urandom, $urandom, 1'($urandom), int'($urandom_range(0, 3)),
                   (i % 10) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
